// File: rtl/snl_pkg.sv
// Shared definitions for the snakes-and-ladders turn engine and its
// neighbours (display, scoring): FSM states, square width, the "no winner"
// code and the snake/ladder table.
package snl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        JUMP,
        CHECK,
        WON
    } state_t;

    localparam int SQ_W = 7;
    localparam logic [3:0] NO_WINNER = 4'd0;

    // Six ladders followed by six snakes. No destination is also a source,
    // so a single lookup is always final.
    localparam int MAP_N = 12;
    localparam logic [SQ_W-1:0] MAP_SRC [MAP_N] = '{
        7'd4,  7'd9,  7'd28, 7'd40, 7'd63, 7'd71,
        7'd17, 7'd54, 7'd62, 7'd87, 7'd93, 7'd99
    };
    localparam logic [SQ_W-1:0] MAP_DST [MAP_N] = '{
        7'd14, 7'd31, 7'd84, 7'd59, 7'd81, 7'd91,
        7'd7,  7'd34, 7'd19, 7'd24, 7'd73, 7'd78
    };

endpackage

// File: rtl/snl_board_map.sv
// Combinational board lookup: returns the destination square of a snake or
// ladder starting on `square`, or `square` itself when there is none.
// Ports:
//   square  in  7 : square the token landed on
//   mapped  out 7 : square after the snake/ladder is applied
module snl_board_map
    import snl_pkg::*;
(
    input  logic [SQ_W-1:0] square,
    output logic [SQ_W-1:0] mapped
);

    logic [MAP_N-1:0] hit;

    generate
        for (genvar gi = 0; gi < MAP_N; gi++) begin : g_hit
            assign hit[gi] = (square == MAP_SRC[gi]);
        end
    endgenerate

    // Sources are unique, so at most one hit bit is set.
    always_comb begin
        mapped = square;
        for (int i = 0; i < MAP_N; i++) begin
            if (hit[i]) begin
                mapped = MAP_DST[i];
            end
        end
    end

endmodule

// File: rtl/game_turn_engine.sv
// Snakes-and-ladders turn engine. Accepts dice rolls over valid/ready, moves
// the current player, applies the board map, rotates turns (a six rolls
// again) and latches the first player landing exactly on BOARD_LAST.
// Ports:
//   clock          in  1  : rising-edge clock
//   reset          in  1  : asynchronous active-high reset
//   new_game       in  1  : synchronous restart, beats any handshake
//   roll_valid     in  1  : dice value offered
//   roll_value     in  3  : dice value (1..6 legal; 0/7 are consumed as no-ops)
//   roll_ready     out 1  : high only in IDLE
//   current_player out 2  : zero-based player whose turn it is
//   positions      out 28 : four 7-bit squares, player 0 in [6:0]
//   winner         out 4  : 0 = none, else winning index + 1
module game_turn_engine
    import snl_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int BOARD_LAST  = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        new_game,
    input  logic        roll_valid,
    input  logic [2:0]  roll_value,
    output logic        roll_ready,
    output logic [1:0]  current_player,
    output logic [27:0] positions,
    output logic [3:0]  winner
);

    localparam logic [7:0] LAST8 = 8'(BOARD_LAST);

    state_t          state_reg, state_next;
    logic [2:0]      roll_reg, roll_next;
    logic [1:0]      player_reg, player_next;
    logic [3:0]      winner_reg, winner_next;
    logic [SQ_W-1:0] pos_reg  [4];
    logic [SQ_W-1:0] pos_next [4];
    logic [SQ_W-1:0] pos_init [4];

    logic [SQ_W-1:0] cur_pos;
    logic [SQ_W-1:0] mapped_pos;
    logic [7:0]      raw_pos;
    logic            roll_legal;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pos
            // Seats beyond NUM_PLAYERS sit at 0 and are never written.
            assign pos_init[gi] = (gi < NUM_PLAYERS) ? 7'd1 : 7'd0;
            assign positions[gi*SQ_W +: SQ_W] = pos_reg[gi];
        end
    endgenerate

    assign cur_pos    = pos_reg[player_reg];
    assign raw_pos    = {1'b0, cur_pos} + {5'd0, roll_reg};
    assign roll_legal = (roll_reg != 3'd0) && (roll_reg != 3'd7);

    snl_board_map u_map (
        .square (cur_pos),
        .mapped (mapped_pos)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            roll_reg   <= 3'd0;
            player_reg <= 2'd0;
            winner_reg <= NO_WINNER;
            for (int i = 0; i < 4; i++) begin
                pos_reg[i] <= pos_init[i];
            end
        end else begin
            state_reg  <= state_next;
            roll_reg   <= roll_next;
            player_reg <= player_next;
            winner_reg <= winner_next;
            pos_reg    <= pos_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        roll_next   = roll_reg;
        player_next = player_reg;
        winner_next = winner_reg;
        pos_next    = pos_reg;

        if (new_game) begin
            state_next  = IDLE;
            player_next = 2'd0;
            winner_next = NO_WINNER;
            pos_next    = pos_init;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (roll_valid) begin
                        roll_next  = roll_value;
                        state_next = MOVE;
                    end
                end
                MOVE: begin
                    if (!roll_legal) begin
                        state_next = CHECK;
                    end else begin
                        // Overshooting the last square leaves the token put.
                        if (raw_pos <= LAST8) begin
                            pos_next[player_reg] = raw_pos[SQ_W-1:0];
                        end
                        state_next = JUMP;
                    end
                end
                JUMP: begin
                    pos_next[player_reg] = mapped_pos;
                    state_next = CHECK;
                end
                CHECK: begin
                    if (roll_legal && (cur_pos == LAST8[SQ_W-1:0])) begin
                        winner_next = {2'b00, player_reg} + 4'd1;
                        state_next  = WON;
                    end else begin
                        if (roll_legal && (roll_reg != 3'd6)) begin
                            player_next = (player_reg == 2'(NUM_PLAYERS - 1)) ?
                                          2'd0 : player_reg + 2'd1;
                        end
                        state_next = IDLE;
                    end
                end
                WON: begin
                    state_next = WON;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign roll_ready     = (state_reg == IDLE);
    assign current_player = player_reg;
    assign winner         = winner_reg;

endmodule

// File: tb/tb_game_turn_engine.sv
// Bench for game_turn_engine: a behavioural game model pushes the expected
// raw/mapped positions, turn and winner of every roll to a queue; they are
// popped and compared as the engine steps through MOVE/JUMP/CHECK.
module tb_game_turn_engine;

    logic        clock;
    logic        reset;
    logic        new_game;
    logic        roll_valid;
    logic [2:0]  roll_value;
    logic        roll_ready;
    logic [1:0]  current_player;
    logic [27:0] positions;
    logic [3:0]  winner;

    logic        r2_valid;
    logic [2:0]  r2_value;
    logic        r2_ready;
    logic [1:0]  cp2;
    logic [27:0] pos2;
    logic [3:0]  win2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [27:0] raw_pos;
        logic [27:0] map_pos;
        logic [1:0]  cp;
        logic [3:0]  win;
        bit          legal;
    } exp_t;

    exp_t sb[$];

    int mpos[4];
    int mcp;
    int mwin;

    game_turn_engine #(.NUM_PLAYERS(4), .BOARD_LAST(100)) dut (
        .clock          (clock),
        .reset          (reset),
        .new_game       (new_game),
        .roll_valid     (roll_valid),
        .roll_value     (roll_value),
        .roll_ready     (roll_ready),
        .current_player (current_player),
        .positions      (positions),
        .winner         (winner)
    );

    game_turn_engine #(.NUM_PLAYERS(2), .BOARD_LAST(100)) dut2 (
        .clock          (clock),
        .reset          (reset),
        .new_game       (new_game),
        .roll_valid     (r2_valid),
        .roll_value     (r2_value),
        .roll_ready     (r2_ready),
        .current_player (cp2),
        .positions      (pos2),
        .winner         (win2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bmap(input int s);
        case (s)
            4:  return 14;
            9:  return 31;
            28: return 84;
            40: return 59;
            63: return 81;
            71: return 91;
            17: return 7;
            54: return 34;
            62: return 19;
            87: return 24;
            93: return 73;
            99: return 78;
            default: return s;
        endcase
    endfunction

    function automatic logic [27:0] pack();
        logic [27:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            v[i*7 +: 7] = 7'(mpos[i]);
        end
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) mpos[i] = 1;
        mcp  = 0;
        mwin = 0;
    endfunction

    // Largest roll that moves toward target t without a snake or passing t;
    // once at t (>= 96) roll the overshoot value that just passes the turn.
    function automatic int steer(input int p, input int t);
        if (p >= t) return 101 - p;
        for (int r = 6; r >= 1; r--) begin
            if ((p + r <= t) && (bmap(p + r) > p) && (bmap(p + r) <= t)) return r;
        end
        return 1;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (roll_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_roll(input int r);
        exp_t e;
        int   idx;
        int   s;
        bit   ok;
        idx     = mcp;
        e.legal = (r >= 1) && (r <= 6);
        if (e.legal) begin
            s = mpos[idx] + r;
            if (s > 100) s = mpos[idx];
            mpos[idx] = s;
            e.raw_pos = pack();
            mpos[idx] = bmap(s);
            e.map_pos = pack();
            if (mpos[idx] == 100) mwin = idx + 1;
            else if (r != 6) mcp = (idx + 1) % 4;
        end else begin
            e.raw_pos = pack();
            e.map_pos = pack();
        end
        e.cp  = 2'(mcp);
        e.win = 4'(mwin);
        sb.push_back(e);

        wait_ready(ok);
        if (!ok) begin
            check("ready_timeout", 32'(roll_ready), 32'd1);
            e = sb.pop_front();
            return;
        end
        roll_value = 3'(r);
        roll_valid = 1'b1;
        @(posedge clock);
        #1 roll_valid = 1'b0;
        e = sb.pop_front();
        if (e.legal) begin
            @(posedge clock); #1;
            check("raw_pos", 32'(positions), 32'(e.raw_pos));
            @(posedge clock); #1;
            check("map_pos", 32'(positions), 32'(e.map_pos));
            @(posedge clock); #1;
        end else begin
            @(posedge clock);
            @(posedge clock); #1;
            check("illegal_pos", 32'(positions), 32'(e.map_pos));
        end
        check("turn", 32'(current_player), 32'(e.cp));
        check("winner", 32'(winner), 32'(e.win));
        check("ready_after", 32'(roll_ready), 32'(e.win == 4'd0));
        $display("roll p%0d value %0d -> pos 0x%07h turn %0d winner %0d",
                 idx, r, positions, current_player, winner);
    endtask

    task automatic roll2(input int r, input int exp_cp, input logic [27:0] exp_pos);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (r2_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("p2_ready_timeout", 32'(r2_ready), 32'd1);
            return;
        end
        r2_value = 3'(r);
        r2_valid = 1'b1;
        @(posedge clock);
        #1 r2_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("p2_turn", 32'(cp2), 32'(exp_cp));
        check("p2_pos", 32'(pos2), 32'(exp_pos));
        check("p2_unused_zero", 32'(pos2[27:14]), 32'd0);
        $display("2p roll value %0d -> pos 0x%07h turn %0d", r, pos2, cp2);
    endtask

    initial begin
        int  r;
        int  p;
        bit  six_done;
        bit  snake_done;
        bit  ok;
        logic [27:0] frozen;

        reset      = 1'b1;
        new_game   = 1'b0;
        roll_valid = 1'b0;
        roll_value = 3'd0;
        r2_valid   = 1'b0;
        r2_value   = 3'd0;
        six_done   = 1'b0;
        snake_done = 1'b0;
        model_reset();
        #12 reset = 1'b0;
        @(negedge clock);
        check("reset_pos", 32'(positions), 32'(pack()));
        check("reset_turn", 32'(current_player), 32'd0);
        check("reset_winner", 32'(winner), 32'd0);
        check("reset_ready", 32'(roll_ready), 32'd1);
        check("reset_pos_2p", 32'(pos2), 32'h81);

        // Player 0 rolls 3: 4 then ladder to 14, turn passes to 1.
        do_roll(3);
        // Illegal rolls are swallowed without moving or passing the turn.
        do_roll(7);
        do_roll(0);

        // Steer the game: p0 reaches 95 and rolls 6, p1 reaches 95 and
        // rolls 4 into the snake at 99, p2 waits on 97 then wins with 3.
        for (int n = 0; n < 600 && mwin == 0; n++) begin
            p = mpos[mcp];
            case (mcp)
                0: begin
                    if (!six_done && p == 95) begin
                        r = 6;
                        six_done = 1'b1;
                    end else begin
                        r = steer(p, six_done ? 96 : 95);
                    end
                end
                1: begin
                    if (!snake_done && p == 95) begin
                        r = 4;
                        snake_done = 1'b1;
                    end else begin
                        r = steer(p, snake_done ? 96 : 95);
                    end
                end
                2: r = (p == 97 && six_done && snake_done) ? 3 : steer(p, 97);
                default: r = steer(p, 96);
            endcase
            do_roll(r);
        end
        check("winner_is_p3", 32'(winner), 32'd3);

        // Frozen in WON while valid keeps pulsing.
        frozen = positions;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            roll_valid = k[0];
            roll_value = 3'd2;
            check("won_ready_low", 32'(roll_ready), 32'd0);
            check("won_hold", 32'(winner), 32'd3);
            check("won_pos_hold", 32'(positions), 32'(frozen));
        end
        roll_valid = 1'b0;

        // New game restores reset values.
        @(negedge clock);
        new_game = 1'b1;
        @(posedge clock);
        #1 new_game = 1'b0;
        model_reset();
        check("newgame_pos", 32'(positions), 32'(pack()));
        check("newgame_winner", 32'(winner), 32'd0);
        check("newgame_turn", 32'(current_player), 32'd0);
        check("newgame_ready", 32'(roll_ready), 32'd1);

        // new_game during JUMP with a roll offered at the same time.
        wait_ready(ok);
        check("ng_jump_ready", 32'(ok), 32'd1);
        roll_value = 3'd2;
        roll_valid = 1'b1;
        @(posedge clock);
        #1 roll_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        new_game   = 1'b1;
        roll_valid = 1'b1;
        roll_value = 3'd5;
        @(posedge clock);
        #1;
        new_game   = 1'b0;
        roll_valid = 1'b0;
        check("ng_jump_pos", 32'(positions), 32'(pack()));
        check("ng_jump_ready", 32'(roll_ready), 32'd1);
        check("ng_jump_winner", 32'(winner), 32'd0);
        @(posedge clock);
        #1;
        check("ng_jump_no_accept", 32'(positions), 32'(pack()));
        check("ng_jump_still_idle", 32'(roll_ready), 32'd1);

        // Async reset while MOVE is pending.
        do_roll(4);
        wait_ready(ok);
        roll_value = 3'd2;
        roll_valid = 1'b1;
        @(posedge clock);
        #1 roll_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_pos", 32'(positions), 32'(pack()));
        check("async_ready", 32'(roll_ready), 32'd1);
        check("async_turn", 32'(current_player), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("async_no_move", 32'(positions), 32'(pack()));

        // Two-player instance: turn goes 0 -> 1 -> 0.
        roll2(2, 1, 28'h083);
        roll2(2, 0, 28'h183);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_turn_engine.md
# game_turn_engine

- Upstream neighbour of the LED celebration stage: its 4-bit `winner` output drives that stage's `winner` input directly.
- Accepts dice rolls through a valid/ready handshake and keeps the board position of 2–4 players.
- Applies snake/ladder jumps, rotates turns and detects the first player to land exactly on the last square.
- Holds the winner code stable until a new game is requested.

## Interface
Parameters:
- `NUM_PLAYERS`, default 4: number of active players, legal range 2..4.
- `BOARD_LAST`, default 100: winning square; must fit in 7 bits.

Ports:
- `clock` in 1: single clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `new_game` in 1: synchronous restart, effective from any state.
- `roll_valid` in 1: a dice value is offered.
- `roll_value` in 3: dice value; legal values are 1..6.
- `roll_ready` out 1: engine accepts a roll this cycle.
- `current_player` out 2: zero-based index of the player whose turn it is.
- `positions` out 28: four 7-bit squares, player 0 in bits [6:0]; unused players read 0.
- `winner` out 4: 0 = no winner; 1..4 = winning player number (index + 1).

## Operation
- Reset values (`reset` or `new_game`):
  - active players at square 1, unused players at 0;
  - `current_player` = 0, `winner` = 0;
  - state IDLE, so `roll_ready` = 1.
- Priority: `new_game` beats any handshake in the same cycle.
- `roll_ready` = (state == IDLE); it does not depend on `roll_valid`.
- Accept: `roll_valid && roll_ready` latches `roll_value` and moves IDLE→MOVE.
- MOVE:
  - raw = pos + roll, computed at 8 bits;
  - raw > `BOARD_LAST`: position unchanged (overshoot bounce-less rule);
  - otherwise pos ← raw[6:0];
  - go to JUMP.
- JUMP: pos ← map(pos) via the board lookup (identity when the square has no snake or ladder); go to CHECK.
- CHECK, in priority order:
  - pos == `BOARD_LAST`: `winner` ← index+1, go to WON;
  - else roll == 6: same player rolls again, go to IDLE;
  - else `current_player` ← (index+1) mod `NUM_PLAYERS`, go to IDLE.
- Illegal roll (0 or 7): accepted, no movement, turn not advanced; MOVE and JUMP are skipped (MOVE→CHECK with no position change, win impossible) and the engine returns to IDLE.
- WON:
  - `roll_ready` = 0;
  - positions, `winner` and `current_player` frozen;
  - leave only via `new_game` or `reset`.
- Map values (destinations are never sources, so no chaining):
  - ladders: 4→14, 9→31, 28→84, 40→59, 63→81, 71→91;
  - snakes: 17→7, 54→34, 62→19, 87→24, 93→73, 99→78.
- Reset mid-move (any state): returns immediately to reset values; the pending roll is discarded.

## Timing
- Accept edge at end of cycle T. Per-cycle state:
  - T+1: MOVE; raw position visible on `positions` from T+2;
  - T+2: JUMP; mapped position visible from T+3;
  - T+3: CHECK; `winner` / `current_player` update visible from T+4;
  - T+4: IDLE (`roll_ready` = 1) or WON.
- Throughput: one roll per 4 cycles.
- All outputs are registered; no combinational path from inputs to outputs except `roll_ready` from state.
- `winner` changes only at the CHECK→WON edge, at `reset`, or at `new_game`. It never glitches, so it is safe for the downstream counter-enable.

## Structure
- Shared package `snl_pkg` holds:
  - FSM state enum {IDLE, MOVE, JUMP, CHECK, WON};
  - square width constant (7);
  - `NO_WINNER` = 4'd0;
  - the snake/ladder table as constant arrays.
- Sub-module `snl_board_map`: purely combinational 7-bit in → 7-bit out lookup built from the package table. It is reused by the display and scoring blocks.
- Top level contains the FSM, the position register file and the turn counter.

## Test plan
- Reset, then roll 3 for player 0: positions[6:0] = 4 at T+2, 14 (ladder) at T+3; `current_player` = 1 at T+4; `winner` = 0.
- Player 0 at 95 rolls 6: position stays 95, `current_player` stays 0 (six rule), `roll_ready` high at T+4.
- Player 2 at 97 rolls 3: position 100 at T+2; `winner` = 4'd3 at T+4; `roll_ready` stays 0 while `roll_valid` pulses repeatedly.
- Player 1 at 95 rolls 4: position 99 at T+2, 78 (snake) at T+3, `current_player` = 2.
- `NUM_PLAYERS` = 2, rolls 2 then 2: `current_player` sequence 0→1→0; `positions`[27:14] remain 0.
- `new_game` asserted in JUMP with `roll_valid` high: next cycle all active players at 1, state IDLE, `winner` 0, the roll in that cycle is not accepted. Async `reset` pulse mid-MOVE produces the same outcome without waiting for a clock edge.
